// File: rtl/lupanov_lut_eval.sv
// Streaming truth-table evaluator: K-bit row select, one-hot column mask, 2-stage pipe.
// Optional config parity check (adds cfg_par): define LUPANOV_CFG_PARITY_EN.
module lupanov_lut_eval #(
  parameter int N_IN   = 3,
  parameter int K      = 1,
  parameter int LOAD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LOAD_W-1:0] cfg_data,
`ifdef LUPANOV_CFG_PARITY_EN
  input  logic              cfg_par,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic              configured,
  output logic              err
);

  localparam int TT    = 1 << N_IN;
  localparam int RW    = 1 << (N_IN - K);
  localparam int BEATS = TT / LOAD_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (N_IN < 2 || N_IN > 10 || K < 1 || K >= N_IN ||
      LOAD_W < 1 || (TT % LOAD_W) != 0) begin : g_bad_param
    $error("lupanov_lut_eval: illegal parameters");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state_q;
  logic [TT-1:0] tt_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] widx;
  logic          err_q;
  logic          s1_vq;
  logic          s2_vq;
  logic          out_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] col_q;
  logic [RW-1:0] row_d;
  logic [RW-1:0] col_d;
  logic [K-1:0]  hi;
  logic [N_IN-K-1:0] lo;
  logic          adv;
  logic          empty;
  logic          cfg_fire;
  logic          in_fire;
  logic          par_bad;
  logic          last;

  assign adv   = !s2_vq || out_ready;
  assign empty = !s1_vq && !s2_vq;

  always_comb begin
    cfg_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE, LOAD: cfg_ready = 1'b1;
        RUN:        cfg_ready = empty;
        default:    cfg_ready = 1'b0;
      endcase
    end
  end

  // A config beat always wins over a data beat in the same cycle
  assign in_ready = rst_n && (state_q == RUN) && adv &&
                    !(cfg_valid && cfg_ready);

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign widx     = (state_q == LOAD) ? cnt_q : '0;
  assign last     = (widx == CW'(BEATS - 1));

`ifdef LUPANOV_CFG_PARITY_EN
  assign par_bad = (^cfg_data) != cfg_par;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tt_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (cfg_fire) begin
      if (par_bad) begin
        state_q <= IDLE;
        tt_q    <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b1;
      end else begin
        tt_q[widx*LOAD_W +: LOAD_W] <= cfg_data;
        state_q <= last ? RUN : LOAD;
        cnt_q   <= last ? '0 : widx + 1'b1;
      end
    end
  end

  assign hi    = in_data[N_IN-1 -: K];
  assign lo    = in_data[N_IN-K-1:0];
  assign row_d = tt_q[hi*RW +: RW];
  assign col_d = {{(RW-1){1'b0}}, 1'b1} << lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vq <= 1'b0;
      s2_vq <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      out_q <= 1'b0;
    end else if (adv) begin
      s1_vq <= in_fire;
      s2_vq <= s1_vq;
      if (in_fire) begin
        row_q <= row_d;
        col_q <= col_d;
      end
      if (s1_vq) begin
        out_q <= |(row_q & col_q);
      end
    end
  end

  assign out_valid  = s2_vq;
  assign out_data   = out_q;
  assign configured = (state_q == RUN);
  assign err        = err_q;

endmodule

// File: tb/tb_lupanov_lut_eval.sv
// Scoreboard bench for lupanov_lut_eval: reference table model, random traffic.
module tb_lupanov_lut_eval;

  localparam int N_IN   = 3;
  localparam int K      = 1;
  localparam int LOAD_W = 4;
  localparam int TT     = 8;
  localparam int BEATS  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_par = 1'b0;
  logic [LOAD_W-1:0] cfg_data = '0;
  logic in_valid = 1'b0;
  logic [N_IN-1:0] in_data = '0;
  logic out_ready = 1'b1;
  logic cfg_ready, in_ready, out_valid, out_data, configured, err;

  int checks = 0;
  int errors = 0;
  bit q[$];
  bit mon_e;
  logic [TT-1:0] mdl;
  int  m_idx;
  bit  m_run;
  bit  stop;
  logic held;

  always #5 clk = ~clk;

  lupanov_lut_eval #(.N_IN(N_IN), .K(K), .LOAD_W(LOAD_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data(cfg_data),
`ifdef LUPANOV_CFG_PARITY_EN
    .cfg_par(cfg_par),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .configured(configured),
    .err(err)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl = '0;
    m_idx = 0;
    m_run = 1'b0;
    q.delete();
  endtask

  task automatic model_beat(logic [LOAD_W-1:0] d, bit par_ok);
    if (!par_ok) begin
      mdl = '0;
      m_idx = 0;
      m_run = 1'b0;
      return;
    end
    if (m_run) begin
      m_run = 1'b0;
      m_idx = 0;
    end
    mdl[m_idx*LOAD_W +: LOAD_W] = d;
    m_idx++;
    if (m_idx == BEATS) begin
      m_idx = 0;
      m_run = 1'b1;
    end
  endtask

  task automatic cfg_beat(logic [LOAD_W-1:0] d, bit good_par = 1'b1);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data = d;
    cfg_par = good_par ? ^d : ~^d;
    #1;
    while (!cfg_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout actual=0 required=1");
      cfg_valid = 1'b0;
      return;
    end
    model_beat(d, good_par);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(logic [N_IN-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    q.push_back(mdl[d]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load(logic [TT-1:0] t);
    cfg_beat(t[3:0]);
    cfg_beat(t[7:4]);
    check("configured_after_load", configured, m_run);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("drain_queue_empty", q.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual=%0b required=none", out_data);
      end else begin
        mon_e = q.pop_front();
        if (out_data !== mon_e) begin
          errors++;
          $display("FAIL out_data actual=%0b required=%0b", out_data, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_configured", configured, 0);
    check("rst_err", err, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_cfg_ready", cfg_ready, 1);
    check("idle_in_ready", in_ready, 0);

    // majority with latency check on the first input
    load(8'hE8);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 3'd0;
    #1;
    check("lat_in_ready", in_ready, 1);
    q.push_back(mdl[0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_cycle1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2", out_valid, 1);
    for (int i = 1; i < 8; i++) send(3'(i));
    drain();

    // backpressure with XOR3
    load(8'h96);
    fork
      begin
        send(3'd3);
        send(3'd4);
        send(3'd7);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 40);
        out_ready = 1'b0;
        held = out_data;
        check("stall_first_val", held, 0);
        for (int i = 0; i < 3; i++) begin
          #1;
          check("stall_out_valid", out_valid, 1);
          check("stall_out_hold", out_data, held);
          check("stall_in_ready", in_ready, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // reconfigure while an input is in flight
    load(8'hE8);
    fork
      send(3'd7);
      begin
        @(negedge clk);
        cfg_beat(4'h1);
        @(negedge clk);
        #1;
        check("load_in_ready", in_ready, 0);
        check("load_configured", configured, 0);
        cfg_beat(4'h0);
      end
    join
    check("reconf_configured", configured, 1);
    send(3'd0);
    send(3'd7);
    drain();

    // simultaneous config and input with pipeline empty
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data = 4'h5;
    cfg_par = ^cfg_data;
    in_valid = 1'b1;
    in_data = 3'd3;
    #1;
    check("sim_in_ready", in_ready, 0);
    check("sim_cfg_ready", cfg_ready, 1);
    model_beat(4'h5, 1'b1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    cfg_beat(4'hA);
    check("sim_no_out", out_valid, 0);
    check("sim_configured", configured, 1);
    for (int i = 0; i < 8; i++) send(3'(i));
    drain();

    // reset in the middle of a load
    cfg_beat(4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_configured", configured, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load(8'h00);
    for (int i = 0; i < 8; i++) send(3'(i));
    drain();

    // random tables and traffic with random backpressure
    for (int r = 0; r < 4; r++) begin
      load(8'($urandom));
      stop = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(3'($urandom_range(0, 7)));
          end
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
          end
          out_ready = 1'b1;
        end
      join
      drain();
    end

`ifdef LUPANOV_CFG_PARITY_EN
    cfg_beat(4'h8, 1'b0);
    check("par_err", err, 1);
    check("par_configured", configured, 0);
    check("par_cfg_ready", cfg_ready, 1);
    load(8'h3C);
    check("par_err_sticky", err, 1);
    for (int i = 0; i < 8; i++) send(3'(i));
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("par_err_cleared", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    check("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
